// File: rtl/qa_drv_hc_types.sv
// Shared types for the host-channel driver: CCI request/response formats, frame arbiter
// handshake, CSRs and the ring indices exchanged with the status manager.
package qa_drv_hc_types;

  localparam int CCI_CLDATA_WIDTH         = 512;
  localparam int CCI_CLADDR_WIDTH         = 42;
  localparam int CCI_MDATA_WIDTH          = 16;
  localparam int FIFO_FROM_HOST_IDX_WIDTH = 6;

  // Bits of mdata that carry the requesting block's tag; the ROB slot sits in the low bits.
  localparam int READER_TAG_MSB = 15;
  localparam int READER_TAG_LSB = 12;

  typedef logic [CCI_CLDATA_WIDTH-1:0] t_cci_cldata;
  typedef logic [CCI_CLADDR_WIDTH-1:0] t_cci_claddr;
  typedef logic [CCI_MDATA_WIDTH-1:0]  t_cci_mdata;
  typedef logic [1:0]                  t_cci_vc;
  typedef logic [1:0]                  t_cci_cllen;

  typedef enum logic [3:0] {
    eREQ_RDLINE_I = 4'h0,
    eREQ_RDLINE_S = 4'h1
  } t_cci_c0_req;

  typedef enum logic [3:0] {
    eRSP_RDLINE = 4'h0,
    eRSP_UMSG   = 4'h4
  } t_cci_c0_rsp;

  typedef struct packed {
    t_cci_vc     vc_sel;
    t_cci_cllen  cl_len;
    t_cci_c0_req req_type;
    t_cci_claddr address;
    t_cci_mdata  mdata;
  } t_cci_c0_ReqMemHdr;

  typedef struct packed {
    t_cci_vc    vc_sel;
    t_cci_cllen cl_len;
  } t_cci_ReqMemHdrParams;

  typedef struct packed {
    t_cci_c0_rsp resp_type;
    t_cci_mdata  mdata;
  } t_cci_c0_RspMemHdr;

  typedef struct packed {
    t_cci_c0_RspMemHdr hdr;
    t_cci_cldata       data;
    logic              rspValid;
  } t_if_cci_c0_Rx;

  typedef struct packed {
    logic        hc_en;
    t_cci_claddr hc_read_frame;
  } t_qa_drv_hc_csrs;

  typedef struct packed {
    logic              request;
    t_cci_c0_ReqMemHdr readHeader;
  } t_frame_arb_read;

  typedef struct packed {
    logic request;
  } t_frame_arb_write;

  typedef struct packed {
    t_frame_arb_read  read;
    t_frame_arb_write write;
  } t_frame_arb;

  typedef struct packed {
    logic readerGrant;
    logic writerGrant;
  } t_channel_grant_arb;

  typedef logic [FIFO_FROM_HOST_IDX_WIDTH-1:0] t_fifo_from_host_idx;

  typedef struct packed {
    t_fifo_from_host_idx newestReadIdx;
  } t_from_status_mgr_fifo_from_host;

  typedef struct packed {
    t_fifo_from_host_idx oldestReadIdx;
  } t_to_status_mgr_fifo_from_host;

  function automatic t_cci_c0_ReqMemHdr cci_genReqHdr(
    input t_cci_c0_req          req_type,
    input t_cci_claddr          address,
    input t_cci_mdata           mdata,
    input t_cci_ReqMemHdrParams params
  );
    t_cci_c0_ReqMemHdr h;
    h.vc_sel   = params.vc_sel;
    h.cl_len   = params.cl_len;
    h.req_type = req_type;
    h.address  = address;
    h.mdata    = mdata;
    return h;
  endfunction

  function automatic logic cci_c0Rx_isReadRsp(input t_if_cci_c0_Rx rx);
    return rx.rspValid && (rx.hdr.resp_type == eRSP_RDLINE);
  endfunction

endpackage

// File: rtl/qa_drv_hc_read_rob.sv
// Reorder buffer for read responses: slots are allocated in request order, filled in any
// order, and drained strictly from the head.
module qa_drv_hc_read_rob #(
  parameter int N_ENTRIES   = 8,
  parameter int N_DATA_BITS = 512
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          alloc_en,
  output logic [$clog2(N_ENTRIES)-1:0]  alloc_slot,
  input  logic                          wr_en,
  input  logic [$clog2(N_ENTRIES)-1:0]  wr_slot,
  input  logic [N_DATA_BITS-1:0]        wr_data,
  output logic [N_ENTRIES-1:0]          pending,
  input  logic                          deq_en,
  output logic                          head_valid,
  output logic [N_DATA_BITS-1:0]        head_data,
  output logic                          not_full,
  output logic                          not_empty
);

  localparam int SLOT_W = $clog2(N_ENTRIES);

  // One extra pointer bit distinguishes full from empty.
  logic [SLOT_W:0]          alloc_ptr;
  logic [SLOT_W:0]          head_ptr;
  logic [SLOT_W:0]          count;
  logic [SLOT_W-1:0]        head_slot;
  logic [N_ENTRIES-1:0]     pending_q;
  logic [N_ENTRIES-1:0]     pending_next;
  logic [N_ENTRIES-1:0]     valid_q;
  logic [N_ENTRIES-1:0]     valid_next;
  logic [N_DATA_BITS-1:0]   data_q [N_ENTRIES];

  assign alloc_slot = alloc_ptr[SLOT_W-1:0];
  assign head_slot  = head_ptr[SLOT_W-1:0];
  assign count      = alloc_ptr - head_ptr;
  assign not_full   = (count != (SLOT_W+1)'(N_ENTRIES));
  assign not_empty  = (count != '0);
  assign pending    = pending_q;
  assign head_valid = valid_q[head_slot];
  assign head_data  = data_q[head_slot];

  // Allocate, fill and dequeue always touch different slots, so the per-bit updates compose.
  always_comb begin
    pending_next = pending_q;
    valid_next   = valid_q;
    if (deq_en) begin
      valid_next[head_slot] = 1'b0;
    end
    if (wr_en) begin
      pending_next[wr_slot] = 1'b0;
      valid_next[wr_slot]   = 1'b1;
    end
    if (alloc_en) begin
      pending_next[alloc_slot] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      alloc_ptr <= '0;
      head_ptr  <= '0;
      pending_q <= '0;
      valid_q   <= '0;
    end else begin
      if (alloc_en) begin
        alloc_ptr <= alloc_ptr + 1'b1;
      end
      if (deq_en) begin
        head_ptr <= head_ptr + 1'b1;
      end
      pending_q <= pending_next;
      valid_q   <= valid_next;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      data_q[wr_slot] <= wr_data;
    end
  end

endmodule

// File: rtl/qa_drv_hc_fifo_from_host.sv
// Host->FPGA ring reader: requests new ring entries over CCI, reorders the responses and
// hands lines to LEAP in ring order while reporting the consumed index to the status manager.
module qa_drv_hc_fifo_from_host
  import qa_drv_hc_types::*;
#(
  parameter int         MEM_VIRTUAL_CHANNEL = 1,
  parameter int         N_ROB_ENTRIES       = 8,
  parameter logic [3:0] READER_TAG          = 4'h2
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  t_if_cci_c0_Rx                   rx0,
  input  t_qa_drv_hc_csrs                 csr,
  output t_frame_arb                      frame_reader,
  input  t_channel_grant_arb              read_grant,
  input  t_from_status_mgr_fifo_from_host status_to_fifo_from_host,
  output t_to_status_mgr_fifo_from_host   fifo_from_host_to_status,
  output t_cci_cldata                     rx_data,
  output logic                            rx_rdy,
  input  logic                            rx_enable
);

  localparam int ROB_SLOT_W = $clog2(N_ROB_ENTRIES);

  t_fifo_from_host_idx    req_idx;
  t_fifo_from_host_idx    oldest_idx;
  logic                   rd_request;
  logic                   grant_en;
  logic                   rsp_accept;
  logic                   deq_en;
  logic [ROB_SLOT_W-1:0]  alloc_slot;
  logic [ROB_SLOT_W-1:0]  rsp_slot;
  logic [N_ROB_ENTRIES-1:0] rob_pending;
  logic                   rob_head_valid;
  logic                   rob_not_full;
  logic                   rob_not_empty;
  t_cci_mdata             req_mdata;
  t_cci_ReqMemHdrParams   hdr_params;
  logic                   unused_inputs;

  assign rd_request = csr.hc_en
                   && (req_idx != status_to_fifo_from_host.newestReadIdx)
                   && rob_not_full;
  assign grant_en   = read_grant.readerGrant && rd_request;

  assign rsp_slot   = rx0.hdr.mdata[ROB_SLOT_W-1:0];
  assign rsp_accept = cci_c0Rx_isReadRsp(rx0)
                   && (rx0.hdr.mdata[READER_TAG_MSB:READER_TAG_LSB] == READER_TAG)
                   && rob_pending[rsp_slot];

  assign deq_en = rx_enable && rob_head_valid;
  assign rx_rdy = rob_head_valid;

  // Header depends only on registered pointers, so it holds steady until the grant.
  always_comb begin
    req_mdata = '0;
    req_mdata[READER_TAG_MSB:READER_TAG_LSB] = READER_TAG;
    req_mdata[ROB_SLOT_W-1:0] = alloc_slot;
    hdr_params.vc_sel = t_cci_vc'(MEM_VIRTUAL_CHANNEL);
    hdr_params.cl_len = '0;
    frame_reader = '0;
    frame_reader.read.request    = rd_request;
    frame_reader.read.readHeader = cci_genReqHdr(eREQ_RDLINE_S,
                                                 csr.hc_read_frame + t_cci_claddr'(req_idx),
                                                 req_mdata, hdr_params);
    frame_reader.write.request   = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      req_idx    <= '0;
      oldest_idx <= '0;
    end else begin
      if (grant_en) begin
        req_idx <= req_idx + 1'b1;
      end
      if (deq_en) begin
        oldest_idx <= oldest_idx + 1'b1;
      end
    end
  end

  assign fifo_from_host_to_status.oldestReadIdx = oldest_idx;

  qa_drv_hc_read_rob #(
    .N_ENTRIES   (N_ROB_ENTRIES),
    .N_DATA_BITS (CCI_CLDATA_WIDTH)
  ) u_rob (
    .clk        (clk),
    .reset_n    (reset_n),
    .alloc_en   (grant_en),
    .alloc_slot (alloc_slot),
    .wr_en      (rsp_accept),
    .wr_slot    (rsp_slot),
    .wr_data    (rx0.data),
    .pending    (rob_pending),
    .deq_en     (deq_en),
    .head_valid (rob_head_valid),
    .head_data  (rx_data),
    .not_full   (rob_not_full),
    .not_empty  (rob_not_empty)
  );

  assign unused_inputs = ^{rx0.hdr.mdata[READER_TAG_LSB-1:ROB_SLOT_W], read_grant.writerGrant};

  a_rx_enable_legal: assert property (@(posedge clk) disable iff (!reset_n)
    rx_enable |-> rx_rdy);

  a_rdy_nonempty: assert property (@(posedge clk) disable iff (!reset_n)
    rx_rdy |-> rob_not_empty);

endmodule

// File: tb/tb_qa_drv_hc_fifo_from_host.sv
// Directed bench for the host->FPGA ring reader: ordering, reorder, throttling, wrap,
// stale/foreign responses and same-cycle grant/response/dequeue.
module tb_qa_drv_hc_fifo_from_host;
  import qa_drv_hc_types::*;

  localparam logic [41:0] BASE = 42'h0_0000_1000;

  logic                            clk;
  logic                            reset_n;
  t_if_cci_c0_Rx                   rx0;
  t_qa_drv_hc_csrs                 csr;
  t_frame_arb                      frame_reader;
  t_channel_grant_arb              read_grant;
  t_from_status_mgr_fifo_from_host status_in;
  t_to_status_mgr_fifo_from_host   status_out;
  t_cci_cldata                     rx_data;
  logic                            rx_rdy;
  logic                            rx_enable;

  int n_checks = 0;
  int n_fail   = 0;

  qa_drv_hc_fifo_from_host dut (
    .clk                      (clk),
    .reset_n                  (reset_n),
    .rx0                      (rx0),
    .csr                      (csr),
    .frame_reader             (frame_reader),
    .read_grant               (read_grant),
    .status_to_fifo_from_host (status_in),
    .fifo_from_host_to_status (status_out),
    .rx_data                  (rx_data),
    .rx_rdy                   (rx_rdy),
    .rx_enable                (rx_enable)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n    = 1'b0;
    rx_enable  = 1'b0;
    read_grant = '0;
    rx0        = '0;
    status_in.newestReadIdx = '0;
    repeat (3) step();
    reset_n = 1'b1;
  endtask

  task automatic set_newest(input int v);
    status_in.newestReadIdx = t_fifo_from_host_idx'(v);
    #1;
  endtask

  task automatic grant_one(output logic [2:0] slot, output logic [41:0] addr);
    int w = 0;
    while (!frame_reader.read.request && w < 20) begin
      step();
      w++;
    end
    if (!frame_reader.read.request) begin
      chk_eq("request_timeout", 64'(frame_reader.read.request), 64'd1);
      slot = '0;
      addr = '0;
    end else begin
      slot = frame_reader.read.readHeader.mdata[2:0];
      addr = frame_reader.read.readHeader.address;
      read_grant.readerGrant = 1'b1;
      step();
      read_grant.readerGrant = 1'b0;
    end
  endtask

  task automatic grant_all(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (!frame_reader.read.request) break;
      read_grant.readerGrant = 1'b1;
      step();
      read_grant.readerGrant = 1'b0;
      n++;
    end
  endtask

  task automatic drive_rsp(input logic [2:0] slot, input logic [3:0] tag, input logic [63:0] d);
    rx0.rspValid      = 1'b1;
    rx0.hdr.resp_type = eRSP_RDLINE;
    rx0.hdr.mdata     = {tag, 9'b0, slot};
    rx0.data          = {448'b0, d};
  endtask

  task automatic respond(input logic [2:0] slot, input logic [3:0] tag, input logic [63:0] d);
    drive_rsp(slot, tag, d);
    step();
    rx0.rspValid = 1'b0;
  endtask

  task automatic deliver(input string tag, input logic [63:0] exp);
    int w = 0;
    while (!rx_rdy && w < 20) begin
      step();
      w++;
    end
    if (!rx_rdy) begin
      chk_eq({tag, "_rdy_timeout"}, 64'(rx_rdy), 64'd1);
    end else begin
      chk_eq(tag, rx_data[63:0], exp);
      rx_enable = 1'b1;
      step();
      rx_enable = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  s;
    logic [2:0]  slots [4];
    logic [41:0] a;
    logic [41:0] a0;
    int          n;

    csr.hc_en         = 1'b1;
    csr.hc_read_frame = BASE;

    // 1: three lines, in-order responses
    do_reset();
    chk_eq("rst_rx_rdy", 64'(rx_rdy), 64'd0);
    chk_eq("rst_request_empty", 64'(frame_reader.read.request), 64'd0);
    chk_eq("rst_write_request", 64'(frame_reader.write.request), 64'd0);
    chk_eq("rst_oldest", 64'(status_out.oldestReadIdx), 64'd0);
    set_newest(3);
    a0 = frame_reader.read.readHeader.address;
    chk_eq("t1_hdr_mdata", 64'(frame_reader.read.readHeader.mdata), 64'h2000);
    chk_eq("t1_hdr_vc", 64'(frame_reader.read.readHeader.vc_sel), 64'd1);
    chk_eq("t1_hdr_type", 64'(frame_reader.read.readHeader.req_type), 64'(eREQ_RDLINE_S));
    repeat (2) step();
    chk_eq("t1_req_held", 64'(frame_reader.read.request), 64'd1);
    chk_eq("t1_hdr_stable", 64'(frame_reader.read.readHeader.address), 64'(a0));
    for (int i = 0; i < 3; i++) begin
      grant_one(s, a);
      chk_eq("t1_addr", 64'(a), 64'(BASE + 42'(i)));
      chk_eq("t1_slot", 64'(s), 64'(i));
      slots[i] = s;
    end
    chk_eq("t1_req_empty", 64'(frame_reader.read.request), 64'd0);
    chk_eq("t1_rdy_before_rsp", 64'(rx_rdy), 64'd0);
    respond(slots[0], 4'h2, 64'h1000);
    chk_eq("t1_rsp_latency", 64'(rx_rdy), 64'd1);
    respond(slots[1], 4'h2, 64'h1001);
    respond(slots[2], 4'h2, 64'h1002);
    for (int i = 0; i < 3; i++) deliver("t1_data", 64'h1000 + 64'(i));
    chk_eq("t1_oldest", 64'(status_out.oldestReadIdx), 64'd3);
    chk_eq("t1_rdy_drained", 64'(rx_rdy), 64'd0);

    // 2: out-of-order responses 3,1,0,2
    do_reset();
    set_newest(4);
    for (int i = 0; i < 4; i++) grant_one(slots[i], a);
    respond(slots[3], 4'h2, 64'h2003);
    chk_eq("t2_rdy_after_3", 64'(rx_rdy), 64'd0);
    respond(slots[1], 4'h2, 64'h2001);
    chk_eq("t2_rdy_after_1", 64'(rx_rdy), 64'd0);
    respond(slots[0], 4'h2, 64'h2000);
    chk_eq("t2_rdy_after_0", 64'(rx_rdy), 64'd1);
    respond(slots[2], 4'h2, 64'h2002);
    for (int i = 0; i < 4; i++) deliver("t2_order", 64'h2000 + 64'(i));
    chk_eq("t2_oldest", 64'(status_out.oldestReadIdx), 64'd4);

    // 3: ROB full throttles requests
    do_reset();
    set_newest(20);
    grant_all(n);
    chk_eq("t3_grants_full", 64'(n), 64'd8);
    step();
    chk_eq("t3_req_throttled", 64'(frame_reader.read.request), 64'd0);
    respond(3'd0, 4'h2, 64'h3000);
    deliver("t3_head", 64'h3000);
    grant_all(n);
    chk_eq("t3_grants_after_deq", 64'(n), 64'd1);
    chk_eq("t3_oldest", 64'(status_out.oldestReadIdx), 64'd1);

    // 4: ring index wrap
    do_reset();
    set_newest(62);
    for (int i = 0; i < 62; i++) begin
      grant_one(s, a);
      respond(s, 4'h2, 64'h4000 + 64'(i));
      deliver("t4_bulk", 64'h4000 + 64'(i));
    end
    chk_eq("t4_oldest_62", 64'(status_out.oldestReadIdx), 64'd62);
    set_newest(2);
    for (int k = 0; k < 4; k++) begin
      grant_one(slots[k], a);
      chk_eq("t4_wrap_addr", 64'(a), 64'(BASE + 42'((62 + k) % 64)));
    end
    chk_eq("t4_req_empty", 64'(frame_reader.read.request), 64'd0);
    for (int k = 0; k < 4; k++) respond(slots[k], 4'h2, 64'h5000 + 64'(k));
    deliver("t4_wrap_data", 64'h5000);
    chk_eq("t4_oldest_63", 64'(status_out.oldestReadIdx), 64'd63);
    deliver("t4_wrap_data", 64'h5001);
    chk_eq("t4_oldest_wrap", 64'(status_out.oldestReadIdx), 64'd0);
    deliver("t4_wrap_data", 64'h5002);
    deliver("t4_wrap_data", 64'h5003);
    chk_eq("t4_oldest_2", 64'(status_out.oldestReadIdx), 64'd2);

    // 5: foreign tag and stale response after reset
    do_reset();
    set_newest(1);
    grant_one(s, a);
    respond(s, 4'h3, 64'h6BAD);
    repeat (2) step();
    chk_eq("t5_foreign_tag", 64'(rx_rdy), 64'd0);
    respond(s, 4'h2, 64'h6000);
    chk_eq("t5_good_rdy", 64'(rx_rdy), 64'd1);
    deliver("t5_good_data", 64'h6000);
    set_newest(2);
    grant_one(s, a);
    csr.hc_en = 1'b0;
    do_reset();
    respond(s, 4'h2, 64'h6001);
    repeat (2) step();
    chk_eq("t5_stale_rdy", 64'(rx_rdy), 64'd0);
    chk_eq("t5_stale_oldest", 64'(status_out.oldestReadIdx), 64'd0);
    chk_eq("t5_req_disabled", 64'(frame_reader.read.request), 64'd0);
    csr.hc_en = 1'b1;

    // 6: grant + response to slot 1 + dequeue of slot 0 in one cycle
    do_reset();
    set_newest(20);
    grant_one(slots[0], a);
    grant_one(slots[1], a);
    respond(slots[0], 4'h2, 64'h7000);
    chk_eq("t6_rdy_slot0", 64'(rx_rdy), 64'd1);
    chk_eq("t6_req_before", 64'(frame_reader.read.request), 64'd1);
    read_grant.readerGrant = 1'b1;
    rx_enable = 1'b1;
    drive_rsp(slots[1], 4'h2, 64'h7001);
    step();
    read_grant.readerGrant = 1'b0;
    rx_enable    = 1'b0;
    rx0.rspValid = 1'b0;
    chk_eq("t6_slot1_rdy", 64'(rx_rdy), 64'd1);
    chk_eq("t6_slot1_data", rx_data[63:0], 64'h7001);
    chk_eq("t6_oldest", 64'(status_out.oldestReadIdx), 64'd1);
    chk_eq("t6_next_slot", 64'(frame_reader.read.readHeader.mdata[2:0]), 64'd3);
    grant_all(n);
    chk_eq("t6_room_left", 64'(n), 64'd6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
